// File: rtl/sparc_pipe_pkg.sv
// Shared pipeline definitions for the SPARC fetch/decode datapath:
// next-PC select codes and fetch-control FSM state encodings.
package sparc_pipe_pkg;

   localparam logic [1:0] PCSEL_NPC = 2'b00;
   localparam logic [1:0] PCSEL_TA  = 2'b01;
   localparam logic [1:0] PCSEL_ALU = 2'b10;

   typedef enum logic [1:0] {
      S_RUN   = 2'b00,
      S_STALL = 2'b01,
      S_JMPL  = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/if_hazard_ctrl_stall_counter.sv
// Loadable down-counter for load-use freezes; zero flags that the
// current decrement brings the count to zero.
module stall_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             R,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;

   assign count_nxt = count - {{(CNT_W-1){1'b0}}, dec};
   assign zero      = (count_nxt == '0);

   always_ff @(posedge clk or posedge R) begin
      if (R)
         count <= '0;
      else if (load)
         count <= value;
      else if (dec)
         count <= count_nxt;
   end

endmodule

// File: rtl/if_hazard_ctrl.sv
// Fetch-side hazard control: load-use freeze, delayed Bicc/call
// redirects with annul, and jmpl redirect from EX.
module if_hazard_ctrl
   import sparc_pipe_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 3
) (
   input  logic       clk,
   input  logic       R,
   input  logic       load_use,
   input  logic       br_id,
   input  logic       br_taken,
   input  logic       br_always,
   input  logic       annul_bit,
   input  logic       call_id,
   input  logic       jmpl_id,
   output logic [1:0] pc_sel,
   output logic       pc_le,
   output logic       npc_le,
   output logic       ifid_le,
   output logic       ifid_clear,
   output logic       idex_bubble,
   output logic       stalled
);

   fetch_state_t state, state_nxt;
   logic         stalled_q, stalled_d;
   logic         cnt_load, cnt_dec, cnt_zero;
   logic         le;

   stall_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .R     (R),
      .load  (cnt_load),
      .value (CNT_W'(STALL_CYCLES - 1)),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   always_comb begin
      state_nxt   = state;
      pc_sel      = PCSEL_NPC;
      le          = 1'b1;
      ifid_clear  = 1'b0;
      idex_bubble = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      stalled_d   = 1'b0;
      unique case (state)
         S_RUN: begin
            if (load_use) begin
               le          = 1'b0;
               idex_bubble = 1'b1;
               stalled_d   = 1'b1;
               if (STALL_CYCLES > 1) begin
                  cnt_load  = 1'b1;
                  state_nxt = S_STALL;
               end
            end else if (jmpl_id) begin
               state_nxt = S_JMPL;
            end else begin
               if (call_id | (br_id & br_taken))
                  pc_sel = PCSEL_TA;
               // a-bit squashes the delay slot unless a conditional branch is taken
               if (br_id & annul_bit & (~br_taken | br_always))
                  ifid_clear = 1'b1;
            end
         end
         S_STALL: begin
            le          = 1'b0;
            idex_bubble = 1'b1;
            cnt_dec     = 1'b1;
            if (cnt_zero)
               state_nxt = S_RUN;
            else
               stalled_d = 1'b1;
         end
         S_JMPL: begin
            pc_sel     = PCSEL_ALU;
            ifid_clear = 1'b1;
            state_nxt  = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
      if (R) begin
         pc_sel      = PCSEL_NPC;
         le          = 1'b1;
         ifid_clear  = 1'b0;
         idex_bubble = 1'b0;
      end
   end

   assign pc_le   = le;
   assign npc_le  = le;
   assign ifid_le = le;
   assign stalled = stalled_q;

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state     <= S_RUN;
         stalled_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         stalled_q <= stalled_d;
      end
   end

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Directed-vector bench for if_hazard_ctrl (STALL_CYCLES=2) with a
// queue scoreboard checked on the falling edge.
module tb_if_hazard_ctrl;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       R = 1'b1;
   logic       load_use = 1'b0, br_id = 1'b0, br_taken = 1'b0;
   logic       br_always = 1'b0, annul_bit = 1'b0;
   logic       call_id = 1'b0, jmpl_id = 1'b0;
   logic [1:0] pc_sel;
   logic       pc_le, npc_le, ifid_le, ifid_clear, idex_bubble, stalled;

   vec_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   if_hazard_ctrl #(.STALL_CYCLES(2), .CNT_W(3)) dut (
      .clk         (clk),
      .R           (R),
      .load_use    (load_use),
      .br_id       (br_id),
      .br_taken    (br_taken),
      .br_always   (br_always),
      .annul_bit   (annul_bit),
      .call_id     (call_id),
      .jmpl_id     (jmpl_id),
      .pc_sel      (pc_sel),
      .pc_le       (pc_le),
      .npc_le      (npc_le),
      .ifid_le     (ifid_le),
      .ifid_clear  (ifid_clear),
      .idex_bubble (idex_bubble),
      .stalled     (stalled)
   );

   always #5 clk = ~clk;

   // exp = {pc_sel[1:0], pc_le, npc_le, ifid_le, ifid_clear, idex_bubble, stalled}
   localparam logic [7:0] O_RUN  = 8'b00_111_0_0_0;
   localparam logic [7:0] O_TA   = 8'b01_111_0_0_0;
   localparam logic [7:0] O_ANN  = 8'b00_111_1_0_0;
   localparam logic [7:0] O_TAAN = 8'b01_111_1_0_0;
   localparam logic [7:0] O_ALU  = 8'b10_111_1_0_0;
   localparam logic [7:0] O_FRZ0 = 8'b00_000_0_1_0;
   localparam logic [7:0] O_FRZ1 = 8'b00_000_0_1_1;

   // in = {R, load_use, br_id, br_taken, br_always, annul_bit, call_id, jmpl_id}
   task automatic step(input string nm, input logic [7:0] in,
                       input logic [7:0] exp);
      vec_t v;
      @(posedge clk);
      #1;
      {R, load_use, br_id, br_taken, br_always, annul_bit, call_id, jmpl_id} = in;
      v.name = nm;
      v.exp  = exp;
      q.push_back(v);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         vec_t v;
         logic [7:0] got;
         v   = q.pop_front();
         got = {pc_sel, pc_le, npc_le, ifid_le, ifid_clear, idex_bubble, stalled};
         n_vec++;
         if (got !== v.exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", v.name, got, v.exp);
         end
      end
   end

   initial begin
      step("reset",         8'b1000_0000, O_RUN);
      step("idle",          8'b0000_0000, O_RUN);
      step("br_taken",      8'b0011_0000, O_TA);
      step("after_br",      8'b0000_0000, O_RUN);
      step("br_untaken_a",  8'b0010_0100, O_ANN);
      step("ba_a",          8'b0011_1100, O_TAAN);
      step("br_taken_a",    8'b0011_0100, O_TA);
      step("call_no_annul", 8'b0000_0110, O_TA);
      step("br_untaken",    8'b0010_0000, O_RUN);
      step("jmpl_c0",       8'b0000_0001, O_RUN);
      step("jmpl_c1",       8'b0111_0000, O_ALU);
      step("jmpl_c2",       8'b0000_0000, O_RUN);
      step("lu_c0",         8'b0100_0000, O_FRZ0);
      step("lu_c1",         8'b0000_0000, O_FRZ1);
      step("lu_done",       8'b0000_0000, O_RUN);
      step("lu_br_c0",      8'b0111_0000, O_FRZ0);
      step("lu_br_c1",      8'b0011_0000, O_FRZ1);
      step("lu_br_redir",   8'b0011_0000, O_TA);
      step("lu_br_after",   8'b0000_0000, O_RUN);
      step("rst_stall_c0",  8'b0100_0000, O_FRZ0);
      step("rst_in_stall",  8'b1000_0000, O_RUN);
      step("rst_stall_rel", 8'b0000_0000, O_RUN);
      step("rst_jmpl_c0",   8'b0000_0001, O_RUN);
      step("rst_in_jmpl",   8'b1000_0000, O_RUN);
      step("rst_jmpl_rel",  8'b0000_0000, O_RUN);
      step("idle_end",      8'b0000_0000, O_RUN);
      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
